// File: rtl/dsp_fe_word_align.sv
// Word aligner: finds the bit offset of a known training word inside a 2-word
// sliding window, holds lock, and streams the aligned word with 1-cycle latency.
module dsp_fe_word_align #(
    parameter int               Width        = 16,
    parameter logic [Width-1:0] TrainPattern = 16'hF0C5,
    parameter int               LockCount    = 8,
    parameter int               ErrLimit     = 4,
    parameter int               OffW         = $clog2(Width)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_train,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_data,
    output logic             o_valid,
    output logic             o_locked,
    output logic [OffW-1:0]  o_offset,
    output logic [15:0]      o_err_cnt
);

    localparam int MaxLE = (LockCount > ErrLimit) ? LockCount : ErrLimit;
    localparam int CntW  = $clog2(MaxLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [Width-1:0]  prev_q;
    logic [Width-1:0]  data_q, data_d;
    logic              locked_q, locked_d;
    logic [OffW-1:0]   offset_q, offset_d;
    logic [15:0]       err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   miss_q, miss_d;

    logic [2*Width-1:0] win;
    logic [Width-1:0]   slice [Width];
    logic [Width-1:0]   match;
    logic [OffW-1:0]    first_idx;
    logic [CntW-1:0]    cnt_inc;
    logic [CntW-1:0]    miss_inc;

    assign win = {i_data, prev_q};

    // Every candidate offset is compared against the training word in parallel.
    genvar gi;
    generate
        for (gi = 0; gi < Width; gi++) begin : g_slice
            assign slice[gi] = win[gi +: Width];
            assign match[gi] = (slice[gi] == TrainPattern);
        end
    endgenerate

    // Scan from the top down so the lowest matching offset wins.
    always_comb begin
        first_idx = '0;
        for (int k = Width - 1; k >= 0; k--) begin
            if (match[k]) begin
                first_idx = OffW'(k);
            end
        end
    end

    assign cnt_inc  = cnt_q + CntW'(1);
    assign miss_inc = miss_q + CntW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        offset_d = offset_q;
        err_d    = err_q;

        if (!i_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SEARCH;
                    offset_d = '0;
                    err_d    = '0;
                    cnt_d    = '0;
                    miss_d   = '0;
                end
                ST_SEARCH: begin
                    if (|match) begin
                        offset_d = first_idx;
                        cnt_d    = CntW'(1);
                        if (LockCount == 1) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (match[offset_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntW'(LockCount)) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Data words are only judged while upstream claims to send training.
                    if (i_train) begin
                        if (match[offset_q]) begin
                            miss_d = '0;
                        end else begin
                            if (err_q != 16'hFFFF) begin
                                err_d = err_q + 16'd1;
                            end
                            if (miss_inc == CntW'(ErrLimit)) begin
                                state_d = ST_SEARCH;
                                miss_d  = '0;
                                cnt_d   = '0;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        data_d   = slice[offset_q];
        // Built from the next state so the flag drops in the very cycle after a loss.
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            data_q   <= '0;
            locked_q <= 1'b0;
            offset_q <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= i_data;
            data_q   <= data_d;
            locked_q <= locked_d;
            offset_q <= offset_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
        end
    end

    assign o_data    = data_q;
    assign o_locked  = locked_q;
    assign o_valid   = locked_q & ~i_train;
    assign o_offset  = offset_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_dsp_fe_word_align.sv
// Directed bench for dsp_fe_word_align: lock at several offsets, check-phase
// glitch, lock-loss error counting, aligned data streaming and async reset.
module tb_dsp_fe_word_align;

    localparam logic [15:0] P  = 16'hF0C5;
    localparam int          LC = 8;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_train = 1'b0;
    logic [15:0] i_data = '0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_locked;
    logic [3:0]  o_offset;
    logic [15:0] o_err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    dsp_fe_word_align dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_train  (i_train),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_locked (o_locked),
        .o_offset (o_offset),
        .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Word whose 2-word window places the training pattern at bit offset k.
    function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
        logic [31:0] t;
        t = {v, v} << k;
        return t[31:16];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_en = 1'b0; i_train = 1'b0; i_data = '0;
        tick(); tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_lock(output int edges);
        edges = 0;
        while (!o_locked && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic lock_at(input int k, output int edges);
        do_reset();
        i_train = 1'b1;
        i_data  = rotl(P, k);
        i_en    = 1'b1;
        wait_lock(edges);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_en = 1'b1; i_train = 1'b0; i_data = 16'hFFFF;
        tick(); tick();
        n_checks++; if (o_data !== 16'h0) $display("FAIL reset_data got=%h exp=0000", o_data); else n_pass++;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else n_pass++;
        n_checks++; if (o_locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", o_locked); else n_pass++;
        n_checks++; if (o_offset !== 4'd0) $display("FAIL reset_offset got=%0d exp=0", o_offset); else n_pass++;
        n_checks++; if (o_err_cnt !== 16'd0) $display("FAIL reset_err got=%0d exp=0", o_err_cnt); else n_pass++;
        $display("reset: data=%h valid=%b locked=%b offset=%0d err=%0d", o_data, o_valid, o_locked, o_offset, o_err_cnt);
        i_rst = 1'b0; i_en = 1'b0; i_data = '0;
    endtask

    // Edge 1 moves IDLE->SEARCH, edge 2 sees the first full matching window,
    // edge 9 completes LockCount hits: lock appears LockCount+1 edges after enable.
    task automatic test_lock(input int k);
        int edges;
        lock_at(k, edges);
        n_checks++; if (edges !== LC + 1) $display("FAIL lock%0d_latency got=%0d exp=%0d", k, edges, LC + 1); else n_pass++;
        n_checks++; if (o_offset !== 4'(k)) $display("FAIL lock%0d_offset got=%0d exp=%0d", k, o_offset, k); else n_pass++;
        n_checks++; if (o_err_cnt !== 16'd0) $display("FAIL lock%0d_err got=%0d exp=0", k, o_err_cnt); else n_pass++;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL lock%0d_valid got=%b exp=0", k, o_valid); else n_pass++;
        $display("lock k=%0d: edges=%0d offset=%0d locked=%b err=%0d", k, edges, o_offset, o_locked, o_err_cnt);
    endtask

    task automatic test_check_glitch();
        int edges;
        do_reset();
        i_train = 1'b1; i_data = rotl(P, 5); i_en = 1'b1;
        tick(); tick(); tick(); tick();
        i_data = 16'h0000;
        tick();
        n_checks++; if (o_locked !== 1'b0) $display("FAIL glitch_locked got=%b exp=0", o_locked); else n_pass++;
        i_data = rotl(P, 5);
        wait_lock(edges);
        // One window without a match, one SEARCH hit, then LockCount-1 CHECK hits.
        n_checks++; if (edges !== LC + 1) $display("FAIL glitch_relock got=%0d exp=%0d", edges, LC + 1); else n_pass++;
        n_checks++; if (o_offset !== 4'd5) $display("FAIL glitch_offset got=%0d exp=5", o_offset); else n_pass++;
        $display("glitch: relock edges=%0d offset=%0d", edges, o_offset);
    endtask

    // Offset 0 reads only the previous word, so each bad word costs exactly one miss window.
    task automatic test_err_count();
        int edges;
        lock_at(0, edges);
        i_data = 16'h0000;
        tick(); tick(); tick();
        i_data = P;
        tick(); tick();
        n_checks++; if (o_locked !== 1'b1) $display("FAIL err3_locked got=%b exp=1", o_locked); else n_pass++;
        n_checks++; if (o_err_cnt !== 16'd3) $display("FAIL err3_count got=%0d exp=3", o_err_cnt); else n_pass++;
        $display("err: after 3 bad + good locked=%b err=%0d", o_locked, o_err_cnt);
        i_data = 16'h0000;
        tick(); tick(); tick(); tick();
        n_checks++; if (o_locked !== 1'b1) $display("FAIL err6_locked got=%b exp=1", o_locked); else n_pass++;
        n_checks++; if (o_err_cnt !== 16'd6) $display("FAIL err6_count got=%0d exp=6", o_err_cnt); else n_pass++;
        i_data = P;
        tick();
        n_checks++; if (o_locked !== 1'b0) $display("FAIL err7_locked got=%b exp=0", o_locked); else n_pass++;
        n_checks++; if (o_err_cnt !== 16'd7) $display("FAIL err7_count got=%0d exp=7", o_err_cnt); else n_pass++;
        $display("err: after 4 bad locked=%b err=%0d", o_locked, o_err_cnt);
        wait_lock(edges);
        n_checks++; if (o_locked !== 1'b1) $display("FAIL err_relock got=%b exp=1", o_locked); else n_pass++;
        n_checks++; if (o_err_cnt !== 16'd7) $display("FAIL err_hold got=%0d exp=7", o_err_cnt); else n_pass++;
        $display("err: relocked edges=%0d offset=%0d err=%0d", edges, o_offset, o_err_cnt);
    endtask

    task automatic test_ramp();
        int          edges;
        logic [15:0] r_cur;
        logic [15:0] r_prev;
        lock_at(5, edges);
        i_train = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b1) $display("FAIL ramp_valid got=%b exp=1", o_valid); else n_pass++;
        r_prev = 16'h0000;
        for (int n = 0; n < 8; n++) begin
            r_cur  = 16'(n) * 16'h0841 + 16'h1234;
            i_data = {r_cur[10:0], r_prev[15:11]};
            tick();
            if (n >= 1) begin
                n_checks++;
                if (o_data !== r_prev) $display("FAIL ramp_data n=%0d got=%h exp=%h", n, o_data, r_prev);
                else n_pass++;
                $display("ramp n=%0d: data=%h exp=%h valid=%b", n, o_data, r_prev, o_valid);
            end
            r_prev = r_cur;
        end
        i_en = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b0) $display("FAIL en_off_valid got=%b exp=0", o_valid); else n_pass++;
        n_checks++; if (o_locked !== 1'b0) $display("FAIL en_off_locked got=%b exp=0", o_locked); else n_pass++;
        n_checks++; if (o_offset !== 4'd5) $display("FAIL en_off_offset got=%0d exp=5", o_offset); else n_pass++;
        $display("en off: valid=%b locked=%b offset=%0d", o_valid, o_locked, o_offset);
    endtask

    task automatic test_async_reset();
        int edges;
        do_reset();
        i_train = 1'b1; i_data = rotl(P, 5); i_en = 1'b1;
        tick(); tick(); tick();
        #2 i_rst = 1'b1;
        #1;
        n_checks++; if (o_offset !== 4'd0) $display("FAIL arst_check_offset got=%0d exp=0", o_offset); else n_pass++;
        n_checks++; if (o_data !== 16'd0) $display("FAIL arst_check_data got=%h exp=0000", o_data); else n_pass++;
        n_checks++; if (o_locked !== 1'b0) $display("FAIL arst_check_locked got=%b exp=0", o_locked); else n_pass++;
        $display("arst mid-check: offset=%0d data=%h locked=%b", o_offset, o_data, o_locked);
        lock_at(5, edges);
        i_train = 1'b0;
        tick();
        n_checks++; if (o_data !== P) $display("FAIL arst_pre_data got=%h exp=%h", o_data, P); else n_pass++;
        #2 i_rst = 1'b1;
        #1;
        n_checks++; if (o_data !== 16'd0) $display("FAIL arst_lock_data got=%h exp=0000", o_data); else n_pass++;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL arst_lock_valid got=%b exp=0", o_valid); else n_pass++;
        n_checks++; if (o_locked !== 1'b0) $display("FAIL arst_lock_locked got=%b exp=0", o_locked); else n_pass++;
        n_checks++; if (o_offset !== 4'd0) $display("FAIL arst_lock_offset got=%0d exp=0", o_offset); else n_pass++;
        n_checks++; if (o_err_cnt !== 16'd0) $display("FAIL arst_lock_err got=%0d exp=0", o_err_cnt); else n_pass++;
        $display("arst mid-locked: data=%h valid=%b locked=%b offset=%0d", o_data, o_valid, o_locked, o_offset);
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock(5);
        test_lock(0);
        test_lock(15);
        test_check_glitch();
        test_err_count();
        test_ramp();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
